// File: rtl/uart_recv_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_recv_fifo_if
// Output handshake bundle of the UART receiver FIFO.
//   out_data        head entry data (DATA_BITS wide)
//   out_parity_err  head entry parity mismatch
//   out_frame_err   head entry stop-bit error
//   out_valid       FIFO holds at least one entry
//   out_ready       consumer accepts the head entry this cycle
// master: the receiver (drives data/flags/valid), slave: the consumer.
// ---------------------------------------------------------------------------
interface uart_recv_fifo_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] out_data;
   logic                 out_parity_err;
   logic                 out_frame_err;
   logic                 out_valid;
   logic                 out_ready;

   modport master (
      output out_data, out_parity_err, out_frame_err, out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data, out_parity_err, out_frame_err, out_valid,
      output out_ready
   );
endinterface

// File: rtl/uart_recv_fifo.sv
// ---------------------------------------------------------------------------
// uart_recv_fifo
// UART receiver with configurable frame format, 3-sample majority voting,
// false-start rejection, parity/framing error flags and an output FIFO.
// Ports:
//   sys_clk   system clock, rising edge
//   sys_rst   asynchronous active-high reset
//   uart_rxd  asynchronous serial input, idle high
//   out_if    master side of the output handshake (data, flags, valid/ready)
//   overrun   one-cycle pulse when a completed frame is dropped (FIFO full)
//   busy      receiver is outside IDLE
// ---------------------------------------------------------------------------
module uart_recv_fifo #(
   parameter int CLK_FREQUENCY = 10_000_000,
   parameter int UART_BPS      = 115200,
   parameter int DATA_BITS     = 8,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1,
   parameter int FIFO_DEPTH    = 4
)(
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               uart_rxd,
   uart_recv_fifo_if.master   out_if,
   output logic               overrun,
   output logic               busy
);

   localparam int BPS_CNT = CLK_FREQUENCY / UART_BPS;
   localparam int CNT_W   = $clog2(BPS_CNT);
   localparam int MID     = BPS_CNT / 2;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int ENT_W   = DATA_BITS + 2;

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BPS_CNT - 1);
   localparam logic [CNT_W-1:0] C_S0   = CNT_W'(MID - 1);
   localparam logic [CNT_W-1:0] C_S1   = CNT_W'(MID);
   localparam logic [CNT_W-1:0] C_S2   = CNT_W'(MID + 1);
   localparam logic [3:0]       N_DATA    = 4'(DATA_BITS);
   localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
   localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
   } state_t;

   state_t               r_state, w_state_nxt;
   logic                 r_rx_meta, r_rx_s, r_rx_d;
   logic [CNT_W-1:0]     r_clk_cnt;
   logic [3:0]           r_bit_cnt;
   logic                 r_smp0, r_smp1;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_perr, r_ferr;
   logic                 w_fall, w_tick_end, w_at_s2, w_maj, w_par_exp, w_wr;
   logic [ENT_W-1:0]     w_entry;

   logic [ENT_W-1:0]     r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr, w_rd_nxt;
   logic [PTR_W:0]       r_count, w_count_nxt;
   logic [ENT_W-1:0]     r_out;
   logic                 r_valid, r_overrun;
   logic                 w_pop, w_full, w_push, w_drop;

   // ---- Stage: input synchroniser and falling-edge detect ----
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_rx_d    <= 1'b1;
      end else begin
         r_rx_meta <= uart_rxd;
         r_rx_s    <= r_rx_meta;
         r_rx_d    <= r_rx_s;
      end
   end

   assign w_fall     = r_rx_d & ~r_rx_s;
   assign w_tick_end = (r_clk_cnt == C_LAST);
   assign w_at_s2    = (r_clk_cnt == C_S2);
   // Third sample is the live synchronised line at M+1.
   assign w_maj      = (r_smp0 & r_smp1) | (r_smp0 & r_rx_s) | (r_smp1 & r_rx_s);
   assign w_par_exp  = (PARITY == 2) ? ^r_shift : ~^r_shift;
   // Frame error includes the stop bit being decided in this very cycle.
   assign w_entry    = {r_perr, r_ferr | ~w_maj, r_shift};

   // ---- Stage: bit timing and FSM state ----
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state   <= S_IDLE;
         r_clk_cnt <= '0;
         r_bit_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         // Held at 0 in IDLE so START always begins at clk_cnt = 0.
         if (r_state == S_IDLE || w_state_nxt == S_IDLE)
            r_clk_cnt <= '0;
         else
            r_clk_cnt <= w_tick_end ? '0 : r_clk_cnt + 1'b1;
         if (r_state != w_state_nxt)
            r_bit_cnt <= '0;
         else if (w_at_s2 && (r_state == S_DATA || r_state == S_STOP))
            r_bit_cnt <= r_bit_cnt + 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_wr        = 1'b0;
      case (r_state)
         S_IDLE:      if (w_fall) w_state_nxt = S_START;
         S_START: begin
            if (w_at_s2 && w_maj) w_state_nxt = S_IDLE;
            else if (w_tick_end)  w_state_nxt = S_DATA;
         end
         S_DATA: begin
            if (w_tick_end && r_bit_cnt == N_DATA)
               w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
         end
         S_PARITY:    if (w_tick_end) w_state_nxt = S_STOP;
         S_STOP: begin
            if (w_at_s2 && r_bit_cnt == LAST_STOP) begin
               w_wr        = 1'b1;
               // A low last stop bit means a break: wait for the line to idle.
               w_state_nxt = w_maj ? S_IDLE : S_WAIT_HIGH;
            end
         end
         S_WAIT_HIGH: if (r_rx_s) w_state_nxt = S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   // ---- Stage: samples and frame assembly ----
   always_ff @(posedge sys_clk) begin
      if (r_clk_cnt == C_S0) r_smp0 <= r_rx_s;
      if (r_clk_cnt == C_S1) r_smp1 <= r_rx_s;
      if (r_state == S_START) begin
         r_perr <= 1'b0;
         r_ferr <= 1'b0;
      end
      if (w_at_s2) begin
         if (r_state == S_DATA)   r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
         if (r_state == S_PARITY) r_perr  <= (w_maj != w_par_exp);
         if (r_state == S_STOP && !w_maj) r_ferr <= 1'b1;
      end
   end

   // ---- Stage: output FIFO ----
   assign w_pop       = r_valid & out_if.out_ready;
   assign w_full      = (r_count == FULL_CNT);
   assign w_push      = w_wr & (~w_full | w_pop);
   assign w_drop      = w_wr & w_full & ~w_pop;
   assign w_rd_nxt    = r_rd_ptr + PTR_W'(w_pop);
   assign w_count_nxt = r_count + (PTR_W + 1)'(w_push) - (PTR_W + 1)'(w_pop);

   always_ff @(posedge sys_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_entry;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
         r_out     <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         r_rd_ptr  <= w_rd_nxt;
         r_count   <= w_count_nxt;
         r_valid   <= (w_count_nxt != '0);
         r_overrun <= w_drop;
         // Head register: bypass the incoming entry when it becomes the only one.
         if (w_push && r_count == (PTR_W + 1)'(w_pop))
            r_out <= w_entry;
         else
            r_out <= r_mem[w_rd_nxt];
      end
   end

   assign out_if.out_data       = r_out[DATA_BITS-1:0];
   assign out_if.out_frame_err  = r_out[DATA_BITS];
   assign out_if.out_parity_err = r_out[DATA_BITS+1];
   assign out_if.out_valid      = r_valid;
   assign overrun               = r_overrun;
   assign busy                  = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_recv_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_recv_fifo
// Directed plus randomized bench for uart_recv_fifo configured as 8E1,
// BPS_CNT = 86, FIFO depth 4. Expected entries come from a frame-level model
// (queue of {data, parity_err, frame_err}) built from the bits driven.
// ---------------------------------------------------------------------------
module tb_uart_recv_fifo;
   localparam int BPS   = 10_000_000 / 115200;
   localparam int DB    = 8;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rxd = 1'b1;
   logic overrun, busy;

   uart_recv_fifo_if #(.DATA_BITS(DB)) bus();

   uart_recv_fifo #(
      .CLK_FREQUENCY(10_000_000), .UART_BPS(115200), .DATA_BITS(DB),
      .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
   ) dut (
      .sys_clk(clk), .sys_rst(rst), .uart_rxd(rxd),
      .out_if(bus), .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   ent_t q[$];
   int   total = 0;
   int   bad = 0;
   int   ovr_seen = 0;
   int   ovr_exp = 0;

   always @(negedge clk) if (overrun === 1'b1) ovr_seen++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One bit period; optionally a single-cycle inverted pulse mid-bit.
   task automatic send_bit(input logic b, input bit glitch);
      rxd = b;
      if (glitch) begin
         cyc(BPS / 2);
         rxd = ~b;
         cyc(1);
         rxd = b;
         cyc(BPS - BPS / 2 - 1);
      end else begin
         cyc(BPS);
      end
   endtask

   // Frame-level reference: even parity, stop bit must be 1, FIFO of DEPTH.
   task automatic model_frame(input logic [7:0] d, input logic pbit, input logic sbit);
      ent_t e;
      e.d  = d;
      e.pe = (pbit != ^d);
      e.fe = ~sbit;
      if (q.size() < DEPTH) q.push_back(e);
      else ovr_exp++;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                             input int gl_bit);
      send_bit(1'b0, gl_bit == 0);
      for (int i = 0; i < 8; i++) send_bit(d[i], gl_bit == i + 1);
      send_bit(pbit, 1'b0);
      send_bit(sbit, 1'b0);
      model_frame(d, pbit, sbit);
      if (!sbit) send_bit(1'b1, 1'b0);
   endtask

   task automatic pop_check(input string tag);
      ent_t e;
      int   n = 0;
      while (bus.out_valid !== 1'b1 && n < 3 * BPS) begin
         cyc(1);
         n++;
      end
      chk({tag, "_valid"}, bus.out_valid, 1);
      if (q.size() > 0) begin
         e = q.pop_front();
         chk({tag, "_data"}, bus.out_data, e.d);
         chk({tag, "_perr"}, bus.out_parity_err, e.pe);
         chk({tag, "_ferr"}, bus.out_frame_err, e.fe);
      end
      bus.out_ready = 1'b1;
      cyc(1);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      logic [7:0] d, a5;
      logic       pb, sb;
      int         ovr_base;
      bus.out_ready = 1'b0;

      // Reset state
      cyc(3);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_data", bus.out_data, 0);
      chk("rst_perr", bus.out_parity_err, 0);
      chk("rst_ferr", bus.out_frame_err, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      cyc(5);

      // 0xA5 with output-latency checks around the mid stop bit write
      a5 = 8'hA5;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(a5[i], 1'b0);
      send_bit(^a5, 1'b0);
      rxd = 1'b1;
      cyc(40);
      chk("a5_early_valid", bus.out_valid, 0);
      chk("a5_busy_stop", busy, 1);
      cyc(BPS - 40);
      chk("a5_late_valid", bus.out_valid, 1);
      chk("a5_idle", busy, 0);
      model_frame(a5, ^a5, 1'b1);
      pop_check("a5");
      chk("a5_empty", bus.out_valid, 0);

      // Parity error then clean resend
      send_frame(8'h07, 1'b0, 1'b1, -1);
      pop_check("par_bad");
      send_frame(8'h07, 1'b1, 1'b1, -1);
      pop_check("par_ok");

      // False start: 20 low cycles
      rxd = 1'b0;
      cyc(20);
      chk("glitch_busy", busy, 1);
      rxd = 1'b1;
      cyc(BPS);
      chk("glitch_idle", busy, 0);
      chk("glitch_noentry", bus.out_valid, 0);

      // Single-cycle noise inside data bit 2 of 0x3C
      send_frame(8'h3C, ^(8'h3C), 1'b1, 3);
      pop_check("noise");

      // Randomized frames, back-to-back, drained in groups of three
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 3; k++) begin
            d  = 8'($urandom);
            pb = ^d ^ ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 4) != 0);
            send_frame(d, pb, sb, -1);
         end
         for (int k = 0; k < 3; k++) pop_check("rand");
      end

      // Overrun: five frames into a four-deep FIFO
      ovr_base = ovr_seen;
      for (int v = 1; v <= 5; v++) begin
         d = 8'(v);
         send_frame(d, ^d, 1'b1, -1);
         if (v == 4) chk("ovr_after4", ovr_seen - ovr_base, ovr_exp);
      end
      chk("ovr_after5", ovr_seen - ovr_base, ovr_exp);
      chk("ovr_once", ovr_exp, 1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         ent_t e;
         chk("drain_valid", bus.out_valid, 1);
         e = q.pop_front();
         chk("drain_data", bus.out_data, e.d);
         cyc(1);
      end
      chk("drain_empty", bus.out_valid, 0);
      bus.out_ready = 1'b0;

      // Break: line low for two frame times gives one errored entry
      rxd = 1'b0;
      cyc(2 * 11 * BPS);
      model_frame(8'h00, 1'b0, 1'b0);
      rxd = 1'b1;
      cyc(BPS);
      pop_check("break");
      cyc(2);
      chk("break_single", bus.out_valid, 0);
      send_frame(8'h5A, ^(8'h5A), 1'b1, -1);
      pop_check("after_break");

      // Reset during data bit 4 with one entry queued
      send_frame(8'h11, ^(8'h11), 1'b1, -1);
      d = 8'hFF;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(d[i], 1'b0);
      rxd = 1'b0;
      cyc(40);
      rxd = 1'b1;
      rst = 1'b1;
      cyc(2);
      q.delete();
      chk("mrst_valid", bus.out_valid, 0);
      chk("mrst_data", bus.out_data, 0);
      chk("mrst_perr", bus.out_parity_err, 0);
      chk("mrst_ferr", bus.out_frame_err, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_ovr", overrun, 0);
      rst = 1'b0;
      cyc(2 * BPS);
      chk("mrst_still_empty", bus.out_valid, 0);
      send_frame(8'hC3, ^(8'hC3), 1'b1, -1);
      pop_check("after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
